// File: rtl/svadc_wrapper.sv
// svadc_wrapper: DE0-Nano wrapper clocking a 10-bit parallel ADC, tracking windowed min/max and showing a selected statistic on LEDs.
// Optional rising mid-scale trigger/period display enabled by defining WRAPPER_TRIG_EN.
`timescale 1ns/1ps
module svadc_wrapper #(
    parameter int ADC_DIV  = 2,
    parameter int WIN_LOG2 = 10
) (
    input  logic        CLOCK_50,
    input  logic [1:0]  KEY,
    input  logic [3:0]  SW,
    output logic [7:0]  LED,
    output logic [12:0] DRAM_ADDR,
    output logic [1:0]  DRAM_BA,
    output logic [1:0]  DRAM_DQM,
    output logic        DRAM_CKE,
    output logic        DRAM_CLK,
    output logic        DRAM_CS_N,
    output logic        DRAM_RAS_N,
    output logic        DRAM_CAS_N,
    output logic        DRAM_WE_N,
    inout  wire  [15:0] DRAM_DQ,
    inout  wire         I2C_SCLK,
    inout  wire         I2C_SDAT,
    output logic        G_SENSOR_CS_N,
    input  logic        G_SENSOR_INT,
    output logic        ADC_CS_N,
    output logic        ADC_SADDR,
    output logic        ADC_SCLK,
    input  logic        ADC_SDAT,
    inout  wire  [33:0] GPIO_0,
    input  logic [1:0]  GPIO_0_IN,
    inout  wire  [33:0] GPIO_1,
    input  logic [1:0]  GPIO_1_IN,
    inout  wire  [12:0] GPIO_2,
    input  logic [2:0]  GPIO_2_IN
);
    localparam int DW = ADC_DIV > 1 ? $clog2(ADC_DIV) : 1;

    logic [1:0]          r_rst_sync;
    logic [1:0]          r_key1_sync;
    logic                w_rst_n;
    logic [DW-1:0]       r_div;
    logic                r_adc_clk;
    logic                w_wrap;
    logic                w_rise;
    logic [9:0]          w_d;
    logic [9:0]          r_sample;
    logic                r_valid;
    logic [9:0]          r_cur_min;
    logic [9:0]          r_cur_max;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [9:0]          r_lat_min;
    logic [9:0]          r_lat_max;
    logic [9:0]          w_new_min;
    logic [9:0]          w_new_max;
    logic [9:0]          w_diff;
    logic [7:0]          w_led_base;
    logic [7:0]          w_led_sel;
    logic [7:0]          r_led;
    logic                w_unused;

    assign DRAM_CLK      = CLOCK_50;
    assign DRAM_CKE      = 1'b0;
    assign DRAM_CS_N     = 1'b1;
    assign DRAM_RAS_N    = 1'b1;
    assign DRAM_CAS_N    = 1'b1;
    assign DRAM_WE_N     = 1'b1;
    assign DRAM_DQM      = 2'b11;
    assign DRAM_ADDR     = '0;
    assign DRAM_BA       = '0;
    assign DRAM_DQ       = 'z;
    assign I2C_SCLK      = 1'bz;
    assign I2C_SDAT      = 1'bz;
    assign GPIO_0        = 'z;
    assign GPIO_2        = 'z;
    assign G_SENSOR_CS_N = 1'b1;
    assign ADC_CS_N      = 1'b1;
    assign ADC_SCLK      = 1'b0;
    assign ADC_SADDR     = 1'b0;
    assign GPIO_1        = {16'bz, r_adc_clk, 17'bz};
    assign w_unused      = ^{G_SENSOR_INT, ADC_SDAT, GPIO_0_IN, GPIO_1_IN, GPIO_2_IN, GPIO_1, SW[2]};

    // Scrambled pin order comes from the ADC board's header routing.
    assign w_d = {GPIO_1[32], GPIO_1[30], GPIO_1[31], GPIO_1[29], GPIO_1[33],
                  GPIO_1[27], GPIO_1[25], GPIO_1[19], GPIO_1[23], GPIO_1[21]};

    always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
        if (!KEY[0]) r_rst_sync <= '0;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_wrap = r_div == DW'(ADC_DIV - 1);
    assign w_rise = w_wrap && !r_adc_clk;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_div       <= '0;
            r_adc_clk   <= 1'b0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_key1_sync <= '0;
        end else begin
            r_div       <= w_wrap ? '0 : r_div + 1'b1;
            r_adc_clk   <= w_wrap ? ~r_adc_clk : r_adc_clk;
            r_sample    <= w_rise ? w_d : r_sample;
            r_valid     <= w_rise;
            r_key1_sync <= {r_key1_sync[0], KEY[1]};
        end
    end

    assign w_new_min = r_sample < r_cur_min ? r_sample : r_cur_min;
    assign w_new_max = r_sample > r_cur_max ? r_sample : r_cur_max;

    // The closing sample of a window is folded into the latched values, so nothing is lost at the boundary.
    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cur_min <= 10'h3FF;
            r_cur_max <= '0;
            r_cnt     <= '0;
            r_lat_min <= '0;
            r_lat_max <= '0;
        end else if (!r_key1_sync[1]) begin
            r_cur_min <= 10'h3FF;
            r_cur_max <= '0;
            r_cnt     <= '0;
        end else if (r_valid) begin
            r_cnt     <= r_cnt + 1'b1;
            r_cur_min <= &r_cnt ? 10'h3FF : w_new_min;
            r_cur_max <= &r_cnt ? 10'h000 : w_new_max;
            r_lat_min <= &r_cnt ? w_new_min : r_lat_min;
            r_lat_max <= &r_cnt ? w_new_max : r_lat_max;
        end
    end

    assign w_diff     = r_lat_max >= r_lat_min ? r_lat_max - r_lat_min : '0;
    assign w_led_base = SW[1] ? (SW[0] ? w_diff[9:2] : r_lat_min[9:2])
                              : (SW[0] ? r_lat_max[9:2] : r_sample[9:2]);

`ifdef WRAPPER_TRIG_EN
    logic        r_armed;
    logic [15:0] r_pcnt;
    logic [15:0] r_period;
    logic        w_fire;

    // Arm below 496, fire at or above 528: the gap rejects noise around mid-scale.
    assign w_fire = r_valid && r_armed && r_sample >= 10'd528;

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_armed  <= 1'b0;
            r_pcnt   <= '0;
            r_period <= '0;
        end else if (r_valid) begin
            r_armed  <= r_sample < 10'd496 ? 1'b1 : (w_fire ? 1'b0 : r_armed);
            r_pcnt   <= w_fire ? '0 : (&r_pcnt ? r_pcnt : r_pcnt + 1'b1);
            r_period <= w_fire ? (&r_pcnt ? r_pcnt : r_pcnt + 1'b1) : r_period;
        end
    end

    assign w_led_sel = SW[2] ? (r_period > 16'd255 ? r_period[15:8] : r_period[7:0]) : w_led_base;
`else
    assign w_led_sel = w_led_base;
`endif

    always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
        if (!w_rst_n)   r_led <= '0;
        else if (!SW[3]) r_led <= w_led_sel;
    end
    assign LED = r_led;
endmodule

// File: tb/tb_svadc_wrapper.sv
// tb_svadc_wrapper: randomized scoreboard bench for svadc_wrapper with a queue-based window model.
`timescale 1ns/1ps
module tb_svadc_wrapper;
    localparam int WIN = 1 << 10;

    logic        clk = 1'b0;
    logic [1:0]  key;
    logic [3:0]  sw;
    logic [9:0]  d;
    logic [7:0]  led;
    logic [12:0] dram_addr;
    logic [1:0]  dram_ba, dram_dqm;
    logic        dram_cke, dram_clk, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n;
    logic        g_cs_n, adc_cs_n, adc_saddr, adc_sclk;
    wire  [15:0] dram_dq;
    wire         i2c_sclk, i2c_sdat;
    wire  [33:0] gpio0, gpio1;
    wire  [12:0] gpio2;
    wire         adc_clk;

    always #10 clk = ~clk;

    assign gpio1[32] = d[9];
    assign gpio1[30] = d[8];
    assign gpio1[31] = d[7];
    assign gpio1[29] = d[6];
    assign gpio1[33] = d[5];
    assign gpio1[27] = d[4];
    assign gpio1[25] = d[3];
    assign gpio1[19] = d[2];
    assign gpio1[23] = d[1];
    assign gpio1[21] = d[0];
    assign adc_clk   = gpio1[17];

    svadc_wrapper dut (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .LED(led),
        .DRAM_ADDR(dram_addr), .DRAM_BA(dram_ba), .DRAM_DQM(dram_dqm), .DRAM_CKE(dram_cke),
        .DRAM_CLK(dram_clk), .DRAM_CS_N(dram_cs_n), .DRAM_RAS_N(dram_ras_n),
        .DRAM_CAS_N(dram_cas_n), .DRAM_WE_N(dram_we_n), .DRAM_DQ(dram_dq),
        .I2C_SCLK(i2c_sclk), .I2C_SDAT(i2c_sdat), .G_SENSOR_CS_N(g_cs_n), .G_SENSOR_INT(1'b0),
        .ADC_CS_N(adc_cs_n), .ADC_SADDR(adc_saddr), .ADC_SCLK(adc_sclk), .ADC_SDAT(1'b0),
        .GPIO_0(gpio0), .GPIO_0_IN(2'b00), .GPIO_1(gpio1), .GPIO_1_IN(2'b00),
        .GPIO_2(gpio2), .GPIO_2_IN(3'b000)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] exp;
        int         cexp;
    } item_t;
    item_t q[$];

    int         m_s, m_lmin, m_lmax;
    logic [7:0] m_led;
    int         win[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] src(input logic [1:0] sel);
        int v;
        v = sel == 2'd0 ? m_s / 4 : sel == 2'd1 ? m_lmax / 4 : sel == 2'd2 ? m_lmin / 4
          : (m_lmax >= m_lmin ? (m_lmax - m_lmin) / 4 : 0);
        return 8'(v);
    endfunction

    // At each ADC clock rise: account for the sample just captured, then present the next stimulus.
    task automatic step(input logic [9:0] dn, input logic [3:0] swn, input logic k1n, input int cexp);
        int mn, mx;
        logic [7:0] e;
        @(posedge adc_clk);
        #2;
        m_s = d;
        if (!key[1]) win.delete();
        else begin
            win.push_back(int'(d));
            if (win.size() == WIN) begin
                mn = 1023;
                mx = 0;
                foreach (win[j]) begin
                    if (win[j] < mn) mn = win[j];
                    if (win[j] > mx) mx = win[j];
                end
                m_lmin = mn;
                m_lmax = mx;
                win.delete();
            end
        end
        sw = swn;
        e = sw[3] ? m_led : src(sw[1:0]);
        m_led = e;
        q.push_back('{e, cexp});
        d = dn;
        key[1] = k1n;
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(posedge adc_clk);
            repeat (2) @(posedge clk);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                check("led_model", int'(led), int'(it.exp));
                if (it.cexp >= 0) check("led_spec", int'(led), it.cexp);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: run still active at %0t, limit 1000000 ns", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stim
        time t1, t2;
        logic [3:0] cur_sw;
        key = 2'b00;
        sw = 4'b0000;
        d = '0;
        m_s = 0;
        m_lmin = 0;
        m_lmax = 0;
        m_led = '0;
        #50;
        check("rst_led", int'(led), 0);
        check("rst_adc_clk", int'(adc_clk), 0);
        check("rst_dram_cs_n", int'(dram_cs_n), 1);
        check("rst_dram_cke", int'(dram_cke), 0);
        check("rst_dram_dqm", int'(dram_dqm), 3);
        @(posedge clk) #1 check("dram_clk_hi", int'(dram_clk), 1);
        @(negedge clk) #1 check("dram_clk_lo", int'(dram_clk), 0);
        #24 key[0] = 1'b1;
        @(posedge adc_clk) t1 = $time;
        @(posedge adc_clk) t2 = $time;
        check("adc_period_ns", int'(t2 - t1), 80);
        cur_sw = 4'b0000;
        for (int i = 0; i < 2600; i++) begin
            if ($urandom_range(0, 49) == 0) cur_sw = 4'($urandom_range(0, 15)) & 4'b1011;
            step(10'($urandom), cur_sw, i < 2 ? 1'b0 : ($urandom_range(0, 1499) != 0), -1);
        end
        step(10'h2A5, 4'b0000, 1'b1, -1);
        step(10'($urandom), 4'b0000, 1'b1, 8'hA9);
        step(10'($urandom), 4'b1000, 1'b1, 8'hA9);
        step(10'($urandom), 4'b1000, 1'b1, 8'hA9);
        step(10'd0, 4'b0000, 1'b0, -1);
        for (int v = 0; v < WIN; v++) step(10'(v), 4'b0000, 1'b1, -1);
        step(10'd0, 4'b0001, 1'b1, 8'hFF);
        step(10'd0, 4'b0010, 1'b1, 8'h00);
        step(10'd0, 4'b0011, 1'b1, 8'hFF);
        step(10'd5, 4'b0001, 1'b0, 8'hFF);
        step(10'd5, 4'b0001, 1'b1, 8'hFF);
        step(10'd0, 4'b0000, 1'b1, 8'h01);
        repeat (4) @(posedge clk);
        #1 check("sb_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
